// File: rtl/score_pkg.sv
// Shared types and helpers for the score board: FSM state, two-digit BCD score, 7-segment decode.
package score_pkg;

  typedef enum logic {PLAY, GAME_OVER} sb_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes show nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
      r.tens = v.tens;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_board_seg7_scan.sv
// Multiplexed 4-digit 7-segment driver: refresh divider, digit index and registered seg/an/dp.
module seg7_scan
  import score_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0][3:0] digits,
  input  logic [3:0]      blank,
  output logic [6:0]      seg,
  output logic [3:0]      an,
  output logic            dp
);

  localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            dp_q, dp_d;
  logic            tick;

  // Outputs load on the tick for the current index; index 0 is the leftmost digit.
  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? '0 : div_q + DivW'(1);
    idx_d = idx_q;
    seg_d = seg_q;
    an_d  = an_q;
    dp_d  = dp_q;
    if (tick) begin
      idx_d = idx_q + 2'd1;
      an_d  = ~(4'b1000 >> idx_q);
      seg_d = blank[idx_q] ? SEG_BLANK : seg_decode(digits[idx_q]);
      dp_d  = (idx_q != 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= 2'd0;
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
      dp_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: rtl/score_board.sv
// Two-player BCD score keeper with match-win detection driving a 4-digit display.
// Optional SCORE_BLINK_EN: winner's digits blink while the match is over.
module score_board
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned REFRESH_DIV = 100000
`ifdef SCORE_BLINK_EN
  ,
  parameter int unsigned BLINK_LOG2  = 24
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       score1,
  input  logic       score2,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       game_over,
  output logic       winner
);

  localparam bcd2_t WinBcd = '{tens: 4'(WIN_SCORE / 10), ones: 4'(WIN_SCORE % 10)};

  logic      s1_q, s2_q, clr_q;
  logic      ev1, ev2, ev_clr;
  bcd2_t     p1_q, p1_d, p2_q, p2_d;
  sb_state_t state_q, state_d;
  logic      winner_q, winner_d;
  logic      blink_off;
  logic [3:0][3:0] scan_digits;
  logic [3:0]      scan_blank;

  always_comb begin
    ev1      = score1 & ~s1_q;
    ev2      = score2 & ~s2_q;
    ev_clr   = clear & ~clr_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    state_d  = state_q;
    winner_d = winner_q;
    if (ev_clr) begin
      p1_d     = '0;
      p2_d     = '0;
      state_d  = PLAY;
      winner_d = 1'b0;
    end else if (state_q == PLAY) begin
      if (ev1) p1_d = bcd_inc(p1_q);
      if (ev2) p2_d = bcd_inc(p2_q);
      // Player 1 takes precedence when both reach the target together.
      if (ev1 && (p1_d == WinBcd)) begin
        state_d  = GAME_OVER;
        winner_d = 1'b0;
      end else if (ev2 && (p2_d == WinBcd)) begin
        state_d  = GAME_OVER;
        winner_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      clr_q    <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      state_q  <= PLAY;
      winner_q <= 1'b0;
    end else begin
      s1_q     <= score1;
      s2_q     <= score2;
      clr_q    <= clear;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

`ifdef SCORE_BLINK_EN
  logic [BLINK_LOG2:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (ev_clr)                  blink_d = '0;
    else if (state_q == GAME_OVER) blink_d = blink_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_d;
  end

  // First half-period after the win is the blanked phase.
  assign blink_off = (state_q == GAME_OVER) && !blink_q[BLINK_LOG2];
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    scan_digits[0] = p1_q.tens;
    scan_digits[1] = p1_q.ones;
    scan_digits[2] = p2_q.tens;
    scan_digits[3] = p2_q.ones;
    scan_blank[0]  = (p1_q.tens == 4'd0) || (blink_off && !winner_q);
    scan_blank[1]  = blink_off && !winner_q;
    scan_blank[2]  = (p2_q.tens == 4'd0) || (blink_off && winner_q);
    scan_blank[3]  = blink_off && winner_q;
  end

  seg7_scan #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .digits(scan_digits),
    .blank (scan_blank),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  assign game_over = (state_q == GAME_OVER);
  assign winner    = winner_q;

endmodule
